reg_file_wb: RTL

// - Integer register file: the consumer end of the writeback path.
// - Takes writeback's write_register/write_data/RegWrite/MemToReg, commits them on the clock edge,
//   and serves two combinational read ports to decode (stage2).
// - Holds a per-register load scoreboard and raises load_use_stall when decode reads a pending load

---
 rtl/reg_file_wb.sv | 117 +++++++++++
 1 files changed

// File: rtl/reg_file_wb.sv
// Integer register file at the writeback end: 2 read ports, load scoreboard, write counter.
// Optional macro REGFILE_BYPASS_EN enables same-cycle write-through bypass and stall masking.
module reg_file_wb #(
    parameter int XLEN = 64,
    parameter int NREG = 32,
    parameter int CNTW = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [4:0]             rs1_addr,
    input  logic [4:0]             rs2_addr,
    output logic signed [XLEN-1:0] rs1_data,
    output logic signed [XLEN-1:0] rs2_data,
    input  logic [4:0]             write_register_in,
    input  logic signed [XLEN-1:0] write_data_in,
    input  logic                   RegWrite_in,
    input  logic                   MemToReg_in,
    input  logic                   load_issue,
    input  logic [4:0]             load_rd,
    output logic                   load_use_stall,
    output logic [CNTW-1:0]        wr_count
);

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] pend;
    logic [NREG-1:0] pend_nxt;
    logic            wr_en;
    logic            ld_wb;
    logic            hit1;
    logic            hit2;

    assign wr_en = RegWrite_in && (write_register_in != 5'd0);
    assign ld_wb = RegWrite_in && MemToReg_in;

    // Commit writeback data; x0 is never written so it stays zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[write_register_in] <= write_data_in;
        end
    end

    // Count committed non-x0 writes, wrapping naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_count <= '0;
        end else if (wr_en) begin
            wr_count <= wr_count + CNTW'(1);
        end
    end

    // Scoreboard next state: clear on load writeback, then set so a newer load wins.
    always_comb begin
        pend_nxt = pend;
        if (ld_wb) begin
            pend_nxt[write_register_in] = 1'b0;
        end
        if (load_issue && (load_rd != 5'd0)) begin
            pend_nxt[load_rd] = 1'b1;
        end
        pend_nxt[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend <= '0;
        end else begin
            pend <= pend_nxt;
        end
    end

    // Read port 1: array, x0 forced to zero, optional write-through.
    always_comb begin
        rs1_data = '0;
        if (rs1_addr != 5'd0) begin
            rs1_data = regs[rs1_addr];
`ifdef REGFILE_BYPASS_EN
            if (wr_en && (write_register_in == rs1_addr)) begin
                rs1_data = write_data_in;
            end
`endif
        end
    end

    // Read port 2: array, x0 forced to zero, optional write-through.
    always_comb begin
        rs2_data = '0;
        if (rs2_addr != 5'd0) begin
            rs2_data = regs[rs2_addr];
`ifdef REGFILE_BYPASS_EN
            if (wr_en && (write_register_in == rs2_addr)) begin
                rs2_data = write_data_in;
            end
`endif
        end
    end

    // Load-use hazard: a source waits on a pending load unless its writeback lands now.
    always_comb begin
        hit1 = pend[rs1_addr] && (rs1_addr != 5'd0);
        hit2 = pend[rs2_addr] && (rs2_addr != 5'd0);
`ifdef REGFILE_BYPASS_EN
        if (ld_wb && (write_register_in == rs1_addr)) begin
            hit1 = 1'b0;
        end
        if (ld_wb && (write_register_in == rs2_addr)) begin
            hit2 = 1'b0;
        end
`endif
        load_use_stall = hit1 || hit2;
    end

endmodule
